mem_unified_dp: RTL and testbench
=================================

# mem_unified_dp

Parametrised dual-port unified instruction/data memory for the CPU core. It replaces the single-port shared BRAM. Port I is a read-only instruction fetch port. Port D is a read/write data port with byte-write enables. Both ports use a valid/ready handshake with configurable read latency, and an optional clear sweep after reset.

## Interface
Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8
- ADDR_W, 13, word address width; depth = 2**ADDR_W
- RD_LAT, 1, read latency in cycles; legal values 1 or 2
- INIT_FILE, "", binary $readmemb image; empty means no preload
- CLR_ON_RST, 0, 1 = zero the whole array after every reset; ignored when INIT_FILE is non-empty

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- i_req  in  1  instruction read request
- i_addr  in  ADDR_W  instruction word address
- i_ready  out  1  port I accepts requests
- i_rdata  out  DATA_W  instruction read data
- i_rvalid  out  1  i_rdata valid this cycle
- d_req  in  1  data request
- d_we  in  1  1 = write, 0 = read
- d_be  in  DATA_W/8  byte write enables; bit k controls bits [8k+7:8k]
- d_addr  in  ADDR_W  data word address
- d_wdata  in  DATA_W  write data
- d_ready  out  1  port D accepts requests
- d_rdata  out  DATA_W  data read data
- d_rvalid  out  1  d_rdata valid this cycle

## Operation
- FSM states: CLEAR and READY.
- After rst, the FSM enters CLEAR if CLR_ON_RST=1 and INIT_FILE is empty; otherwise it enters READY.
- In CLEAR:
  - An internal counter writes 0 to address 0, 1, …, 2**ADDR_W−1, one word per cycle.
  - i_ready = d_ready = 0; requests are ignored.
  - After the last address, the FSM moves to READY.
- In READY:
  - i_ready = d_ready = 1.
  - A request is accepted in any cycle where req & ready = 1.
- Port I read: accepted i_req returns the array word at i_addr.
- Port D read (d_we=0): returns the word at d_addr.
- Port D write (d_we=1):
  - Updates only the bytes whose d_be bit is set.
  - d_be = 0 is a legal no-op.
  - Produces no d_rvalid pulse; d_rdata holds its previous value.
- Ports are independent. Both may be accepted in the same cycle.
- Same-address collision (D write and I read accepted in the same cycle at the same address): behaviour is set by the macro; see Configuration.
- D read and D write never overlap, because one request per cycle is accepted on port D.
- Address wraps modulo 2**ADDR_W; no out-of-range detection.

## Timing
- Reset values:
  - i_rvalid = d_rvalid = 0.
  - i_rdata = d_rdata = 0.
  - i_ready = d_ready = 0 in the reset cycle.
  - Array contents are not affected by rst.
- RD_LAT=1: rdata and rvalid are valid in the cycle after acceptance (registered BRAM output).
- RD_LAT=2: one extra output register; data is valid two cycles after acceptance.
- Back-to-back reads sustain one result per cycle per port. rvalid pulses exactly once per accepted read.
- rdata holds its last value when rvalid = 0.
- Read after write, same address, on port D: a read accepted in the cycle after the write returns the new data.
- rst asserted during CLEAR: the sweep restarts from address 0 on the next cycle.
- rst asserted with reads in flight: all pending rvalid are squashed and no results are delivered.
- CLEAR duration: exactly 2**ADDR_W cycles; ready rises in cycle 2**ADDR_W+1 after rst deasserts.

## Configuration
- Macro: MEM_UNIFIED_DP_FWD_EN.
- Defined:
  - On a same-address collision, port I returns the newly written word.
  - The new word is the old word merged with d_wdata under d_be (write-first).
  - Implemented with a registered address compare and byte-merge mux on the port-I output path.
- Undefined:
  - Port I returns the word as it was before the write (read-first).
  - No compare logic is built.

## Structure
- Shared package mem_pkg holds:
  - state typedef (CLEAR, READY)
  - BE_W = DATA_W/8
  - a byte-merge function (old, new, be)
- Sub-module mem_rd_pipe: the RD_LAT output register stage, with valid tracking and rst squash. It is instantiated once per port.
- The array itself lives in the top module so synthesis infers a true dual-port BRAM.

## Test plan
- CLR_ON_RST=1, ADDR_W=4: deassert rst -> ready low 16 cycles, high on cycle 17; subsequent reads of all 16 addresses return 0.
- Port D write 0xDEADBEEF at 0x5 with be=4'b1111, then write 0x000000AA with be=4'b0001, then read 0x5 -> d_rdata=0xDEADBEAA with d_rvalid one cycle after the read request (RD_LAT=1).
- RD_LAT=2: I reads 0x0,0x1,0x2 on consecutive cycles, preloaded 0x11,0x22,0x33 -> i_rvalid high for 3 consecutive cycles starting 2 cycles after the first request, with data in order.
- Collision: array[0x3]=0x12345678; I read 0x3 and D write 0xFFFFFFFF be=4'b0011 at 0x3 in the same cycle -> i_rdata=0x1234FFFF with macro defined, 0x12345678 without.
- Reset mid-flight: issue a D read, then assert rst the next cycle -> d_rvalid never asserts and d_rdata=0.
- Reset mid-CLEAR at sweep address 7 -> the sweep restarts at 0, and ready rises 2**ADDR_W cycles after rst deasserts.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared types and helpers for the unified dual-port memory.
//   state_t      controller state (CLEAR sweep / READY for requests)
//   BYTE_W       bits per byte lane
//   be_width()   number of byte lanes for a given word width (BE_W = DATA_W/8)
//   merge_byte() select the written byte or the old byte under one enable bit
package mem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int BYTE_W = 8;

  function automatic int be_width(input int data_w);
    return data_w / BYTE_W;
  endfunction

  function automatic logic [BYTE_W-1:0] merge_byte(input logic [BYTE_W-1:0] old_b,
                                                    input logic [BYTE_W-1:0] new_b,
                                                    input logic              be);
    return be ? new_b : old_b;
  endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// mem_rd_pipe: read-result output stage for one memory port.
// Takes the registered BRAM output (raw, valid one cycle after acceptance) and
// delivers it RD_LAT cycles after acceptance with a single rvalid pulse.
// rdata holds its last delivered value while rvalid is low and clears on rst.
// rst squashes every result still in flight, including one due this cycle.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   acc        read accepted this cycle
//   raw        BRAM registered read word (valid the cycle after acc)
//   rdata      delivered read data
//   rvalid     rdata valid this cycle
module mem_rd_pipe #(
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              acc,
  input  logic [DATA_W-1:0] raw,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid
);

  logic              v1_q;
  logic              fin_v;
  logic [DATA_W-1:0] fin_d;
  logic [DATA_W-1:0] hold_q;

  always_ff @(posedge clk) begin
    if (rst) v1_q <= 1'b0;
    else     v1_q <= acc;
  end

  if (RD_LAT == 2) begin : g_lat2
    logic              v2_q;
    logic [DATA_W-1:0] d2_q;

    always_ff @(posedge clk) begin
      if (rst) v2_q <= 1'b0;
      else     v2_q <= v1_q;
    end

    always_ff @(posedge clk) begin
      if (v1_q) d2_q <= raw;
    end

    assign fin_v = v2_q;
    assign fin_d = d2_q;
  end else begin : g_lat1
    assign fin_v = v1_q;
    assign fin_d = raw;
  end

  // Gating with rst keeps a result due in the reset cycle from escaping.
  assign rvalid = fin_v & ~rst;
  assign rdata  = rvalid ? fin_d : hold_q;

  always_ff @(posedge clk) begin
    if (rst) hold_q <= '0;
    else     hold_q <= rdata;
  end

endmodule

// File: rtl/mem_unified_dp.sv
// mem_unified_dp: dual-port unified instruction/data memory.
//   Port I: read-only instruction fetch (i_req/i_addr -> i_rdata/i_rvalid).
//   Port D: read/write data port with byte enables (d_req/d_we/d_be/d_addr/
//           d_wdata -> d_rdata/d_rvalid).
//   Both ports: accept when req & ready, results after RD_LAT cycles.
//   After reset an optional sweep zeroes the array (CLR_ON_RST=1 and no
//   INIT_FILE); ready stays low for the 2**ADDR_W sweep cycles.
// Build option: MEM_UNIFIED_DP_FWD_EN
//   defined   - a D write and I read at the same address in the same cycle
//               return the merged (new) word on port I (write-first)
//   undefined - port I returns the word before the write (read-first)
// Ports: clk, rst (sync, active-high), i_req, i_addr, i_ready, i_rdata,
//        i_rvalid, d_req, d_we, d_be, d_addr, d_wdata, d_ready, d_rdata,
//        d_rvalid.
module mem_unified_dp
  import mem_pkg::*;
#(
  parameter int    DATA_W     = 32,
  parameter int    ADDR_W     = 13,
  parameter int    RD_LAT     = 1,
  parameter string INIT_FILE  = "",
  parameter int    CLR_ON_RST = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_ready,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_rvalid,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_ready,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_rvalid
);

  localparam int BE_W     = be_width(DATA_W);
  localparam int DEPTH    = 2 ** ADDR_W;
  localparam bit DO_CLEAR = (CLR_ON_RST != 0) && (INIT_FILE == "");

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] clr_addr_q;
  logic              clr_we;
  logic              ready;

  // Sweep counter wraps to 0 on the last address, ready for the next reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (DO_CLEAR) state_q <= CLEAR;
      else          state_q <= READY;
      clr_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (clr_we) clr_addr_q <= clr_addr_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    clr_we  = 1'b0;
    ready   = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_we = ~rst;
        if (clr_addr_q == '1) state_d = READY;
      end
      READY: begin
        ready = ~rst;
      end
      default: state_d = state_q;
    endcase
  end

  assign i_ready = ready;
  assign d_ready = ready;

  logic i_acc;
  logic d_wr;
  logic d_rd;

  assign i_acc = i_req & ready;
  assign d_wr  = d_req & ready & d_we;
  assign d_rd  = d_req & ready & ~d_we;

  // Single write port: the sweep and D writes never coincide (ready is low
  // during the sweep).
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr_q] <= '0;
    end else if (d_wr) begin
      for (int k = 0; k < BE_W; k++) begin
        if (d_be[k]) mem[d_addr][k*BYTE_W +: BYTE_W] <= d_wdata[k*BYTE_W +: BYTE_W];
      end
    end
  end

  // Registered BRAM outputs; they only load on an accepted read, so they
  // naturally read the pre-write word on a same-cycle collision.
  logic [DATA_W-1:0] i_raw;
  logic [DATA_W-1:0] d_raw;

  always_ff @(posedge clk) begin
    if (i_acc) i_raw <= mem[i_addr];
  end

  always_ff @(posedge clk) begin
    if (d_rd) d_raw <= mem[d_addr];
  end

  logic [DATA_W-1:0] i_fwd_data;

`ifdef MEM_UNIFIED_DP_FWD_EN
  logic              fwd_hit_q;
  logic [BE_W-1:0]   fwd_be_q;
  logic [DATA_W-1:0] fwd_wdata_q;

  always_ff @(posedge clk) begin
    if (rst) fwd_hit_q <= 1'b0;
    else     fwd_hit_q <= i_acc & d_wr & (i_addr == d_addr);
  end

  always_ff @(posedge clk) begin
    fwd_be_q    <= d_be;
    fwd_wdata_q <= d_wdata;
  end

  always_comb begin
    i_fwd_data = i_raw;
    for (int k = 0; k < BE_W; k++) begin
      i_fwd_data[k*BYTE_W +: BYTE_W] = merge_byte(i_raw[k*BYTE_W +: BYTE_W],
                                                  fwd_wdata_q[k*BYTE_W +: BYTE_W],
                                                  fwd_be_q[k] & fwd_hit_q);
    end
  end
`else
  assign i_fwd_data = i_raw;
`endif

  mem_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_i_pipe (
    .clk    (clk),
    .rst    (rst),
    .acc    (i_acc),
    .raw    (i_fwd_data),
    .rdata  (i_rdata),
    .rvalid (i_rvalid)
  );

  mem_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_d_pipe (
    .clk    (clk),
    .rst    (rst),
    .acc    (d_rd),
    .raw    (d_raw),
    .rdata  (d_rdata),
    .rvalid (d_rvalid)
  );

endmodule

// File: tb/tb_mem_unified_dp.sv
// Bench for mem_unified_dp. Instance a: ADDR_W=4, RD_LAT=1, clear sweep.
// Instance b: ADDR_W=4, RD_LAT=2, no sweep. Reads push the expected word and
// arrival cycle to a per-port queue; negedge monitors pop and compare.
module tb_mem_unified_dp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        a_i_req = 0, a_i_ready, a_i_rvalid;
  logic [3:0]  a_i_addr = '0;
  logic [31:0] a_i_rdata;
  logic        a_d_req = 0, a_d_we = 0, a_d_ready, a_d_rvalid;
  logic [3:0]  a_d_be = '0, a_d_addr = '0;
  logic [31:0] a_d_wdata = '0, a_d_rdata;

  logic        b_i_req = 0, b_i_ready, b_i_rvalid;
  logic [3:0]  b_i_addr = '0;
  logic [31:0] b_i_rdata;
  logic        b_d_req = 0, b_d_we = 0, b_d_ready, b_d_rvalid;
  logic [3:0]  b_d_be = '0, b_d_addr = '0;
  logic [31:0] b_d_wdata = '0, b_d_rdata;

  mem_unified_dp #(.DATA_W(32), .ADDR_W(4), .RD_LAT(1), .INIT_FILE(""), .CLR_ON_RST(1)) u_dut_a (
    .clk(clk), .rst(rst),
    .i_req(a_i_req), .i_addr(a_i_addr), .i_ready(a_i_ready), .i_rdata(a_i_rdata), .i_rvalid(a_i_rvalid),
    .d_req(a_d_req), .d_we(a_d_we), .d_be(a_d_be), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
    .d_ready(a_d_ready), .d_rdata(a_d_rdata), .d_rvalid(a_d_rvalid));

  mem_unified_dp #(.DATA_W(32), .ADDR_W(4), .RD_LAT(2), .INIT_FILE(""), .CLR_ON_RST(0)) u_dut_b (
    .clk(clk), .rst(rst),
    .i_req(b_i_req), .i_addr(b_i_addr), .i_ready(b_i_ready), .i_rdata(b_i_rdata), .i_rvalid(b_i_rvalid),
    .d_req(b_d_req), .d_we(b_d_we), .d_be(b_d_be), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_ready(b_d_ready), .d_rdata(b_d_rdata), .d_rvalid(b_d_rvalid));

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t qa_i[$], qa_d[$], qb_i[$], qb_d[$];
  logic [31:0] ma [16];
  logic [31:0] mb [16];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] tb_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                           input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int k = 0; k < 4; k++) if (be[k]) r[k*8 +: 8] = new_w[k*8 +: 8];
    return r;
  endfunction

  // Monitors: every rvalid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (a_i_rvalid) begin
      if (qa_i.size() == 0) chk("a_i_spurious", {31'b0, a_i_rvalid}, 32'd0);
      else begin e = qa_i.pop_front(); chk("a_i_data", a_i_rdata, e.data); chk("a_i_lat", 32'(cyc), 32'(e.cyc)); end
    end
    if (a_d_rvalid) begin
      if (qa_d.size() == 0) chk("a_d_spurious", {31'b0, a_d_rvalid}, 32'd0);
      else begin e = qa_d.pop_front(); chk("a_d_data", a_d_rdata, e.data); chk("a_d_lat", 32'(cyc), 32'(e.cyc)); end
    end
    if (b_i_rvalid) begin
      if (qb_i.size() == 0) chk("b_i_spurious", {31'b0, b_i_rvalid}, 32'd0);
      else begin e = qb_i.pop_front(); chk("b_i_data", b_i_rdata, e.data); chk("b_i_lat", 32'(cyc), 32'(e.cyc)); end
    end
    if (b_d_rvalid) begin
      if (qb_d.size() == 0) chk("b_d_spurious", {31'b0, b_d_rvalid}, 32'd0);
      else begin e = qb_d.pop_front(); chk("b_d_data", b_d_rdata, e.data); chk("b_d_lat", 32'(cyc), 32'(e.cyc)); end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_d_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] be);
    a_d_req = 1; a_d_we = 1; a_d_addr = addr; a_d_wdata = data; a_d_be = be;
    ma[addr] = tb_merge(ma[addr], data, be);
    tick();
    a_d_req = 0; a_d_we = 0; a_d_be = '0;
  endtask

  task automatic a_d_read(input logic [3:0] addr);
    a_d_req = 1; a_d_we = 0; a_d_addr = addr;
    qa_d.push_back('{ma[addr], cyc + 1});
    tick();
    a_d_req = 0;
  endtask

  task automatic a_i_read(input logic [3:0] addr);
    a_i_req = 1; a_i_addr = addr;
    qa_i.push_back('{ma[addr], cyc + 1});
    tick();
    a_i_req = 0;
  endtask

  task automatic b_d_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] be);
    b_d_req = 1; b_d_we = 1; b_d_addr = addr; b_d_wdata = data; b_d_be = be;
    mb[addr] = tb_merge(mb[addr], data, be);
    tick();
    b_d_req = 0; b_d_we = 0; b_d_be = '0;
  endtask

  task automatic b_d_read(input logic [3:0] addr);
    b_d_req = 1; b_d_we = 0; b_d_addr = addr;
    qb_d.push_back('{mb[addr], cyc + 2});
    tick();
    b_d_req = 0;
  endtask

  task automatic b_i_read(input logic [3:0] addr);
    b_i_req = 1; b_i_addr = addr;
    qb_i.push_back('{mb[addr], cyc + 2});
    tick();
    b_i_req = 0;
  endtask

  // Called right after rst drops; returns the 1-based cycle where a ready rises.
  task automatic count_to_ready(output int n);
    @(negedge clk);
    n = 1;
    chk("b_ready_c1", {31'b0, b_i_ready}, 32'd1);
    while (!a_i_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    logic [31:0] old_w, new_w;
    for (int k = 0; k < 16; k++) begin ma[k] = '0; mb[k] = '0; end

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    chk("rst_i_ready", {31'b0, a_i_ready}, 32'd0);
    chk("rst_d_ready", {31'b0, a_d_ready}, 32'd0);
    chk("rst_i_rvalid", {31'b0, a_i_rvalid}, 32'd0);
    chk("rst_i_rdata", a_i_rdata, 32'd0);
    chk("rst_d_rdata", b_d_rdata, 32'd0);
    tick();

    // Clear sweep: requests held during the sweep must be ignored
    rst = 0;
    a_i_req = 1; a_i_addr = 4'd0;
    count_to_ready(n);
    a_i_req = 0;
    chk("clr_len", 32'(n), 32'd17);
    tick();

    // All 16 words read back as zero on both ports together
    for (int k = 0; k < 16; k++) begin
      a_i_req = 1; a_i_addr = 4'(k);
      a_d_req = 1; a_d_we = 0; a_d_addr = 4'(15 - k);
      qa_i.push_back('{ma[k], cyc + 1});
      qa_d.push_back('{ma[15 - k], cyc + 1});
      tick();
    end
    a_i_req = 0; a_d_req = 0;
    tick();

    // Byte-enable writes, read after write, be=0 no-op, rdata hold
    a_d_write(4'h5, 32'hDEADBEEF, 4'b1111);
    a_d_write(4'h5, 32'h000000AA, 4'b0001);
    a_d_read(4'h5);
    a_d_write(4'h5, 32'h55555555, 4'b0000);
    @(negedge clk);
    chk("a_d_hold", a_d_rdata, 32'hDEADBEAA);
    chk("a_d_wr_novalid", {31'b0, a_d_rvalid}, 32'd0);
    tick();
    a_d_read(4'h5);
    tick();

    // Same-address collision between a D write and an I read
    a_d_write(4'h3, 32'h12345678, 4'b1111);
    old_w = ma[3];
    new_w = tb_merge(old_w, 32'hFFFFFFFF, 4'b0011);
    a_i_req = 1; a_i_addr = 4'h3;
    a_d_req = 1; a_d_we = 1; a_d_addr = 4'h3; a_d_wdata = 32'hFFFFFFFF; a_d_be = 4'b0011;
`ifdef MEM_UNIFIED_DP_FWD_EN
    qa_i.push_back('{new_w, cyc + 1});
`else
    qa_i.push_back('{old_w, cyc + 1});
`endif
    ma[3] = new_w;
    tick();
    a_i_req = 0; a_d_req = 0; a_d_we = 0; a_d_be = '0;
    a_i_read(4'h3);
    tick();

    // RD_LAT=2 instance: back-to-back I reads, then a D read
    b_d_write(4'h0, 32'h00000011, 4'b1111);
    b_d_write(4'h1, 32'h00000022, 4'b1111);
    b_d_write(4'h2, 32'h00000033, 4'b1111);
    b_i_read(4'h0);
    b_i_read(4'h1);
    b_i_read(4'h2);
    b_d_read(4'h2);
    repeat (4) tick();

    // Reset with a D read in flight: squashed, rdata cleared
    a_d_req = 1; a_d_we = 0; a_d_addr = 4'h5;
    tick();
    a_d_req = 0;
    rst = 1;
    @(negedge clk);
    chk("squash_rvalid", {31'b0, a_d_rvalid}, 32'd0);
    tick();
    @(negedge clk);
    chk("squash_rdata", a_d_rdata, 32'd0);
    chk("squash_rvalid2", {31'b0, a_d_rvalid}, 32'd0);
    tick();

    // Reset in the middle of the sweep (sweep address 7): restarts from 0
    rst = 0;
    repeat (7) tick();
    rst = 1;
    tick();
    rst = 0;
    for (int k = 0; k < 16; k++) ma[k] = '0;
    count_to_ready(n);
    chk("clr_restart_len", 32'(n), 32'd17);
    tick();

    // Sweep wiped instance a; instance b kept its contents through rst
    a_d_read(4'h5);
    a_i_read(4'h3);
    b_i_read(4'h1);
    repeat (5) tick();

    chk("a_i_drain", 32'(qa_i.size()), 32'd0);
    chk("a_d_drain", 32'(qa_d.size()), 32'd0);
    chk("b_i_drain", 32'(qb_i.size()), 32'd0);
    chk("b_d_drain", 32'(qb_d.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
